// File: rtl/mssd_frame_tx.sv
// rtl/mssd_frame_tx.sv - MSSD serial frame transmitter: start bit, dest, len, N data bits, then idle gap
module mssd_frame_tx #(
    parameter int IDLE_GAP = 2,
    parameter int LEN_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            dest,
    input  logic [LEN_W-1:0]      len,
    input  logic [2**LEN_W-2:0]   data,
    output logic                  serOut,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);
    localparam int DW = 2**LEN_W - 1;
    localparam int SW = 2 + LEN_W + DW;
    localparam int RW = $clog2(SW + 1);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [RW-1:0] HDR_BITS = RW'(2 + LEN_W);
    localparam logic [RW-1:0] LEN_BITS = RW'(LEN_W);

    typedef enum logic [2:0] {IDLE, START, DEST, LEN, DATA, GAP} state_t;

    state_t            state;
    logic [SW-1:0]     shReg;
    logic [RW-1:0]     remain;
    logic [LEN_W-1:0]  lenR;
    logic [GW-1:0]     gapCnt;
    logic [RW-1:0]     nBits;

    assign nBits = {{(RW-LEN_W){1'b0}}, lenR};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            serOut <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            shReg  <= '0;
            remain <= '0;
            lenR   <= '0;
            gapCnt <= '0;
        end else if (start && ready) begin
            // Payload is left-aligned (shifted by DW-len == ~len) so data[N-1] leads
            // and bits above N-1 fall off the top.
            state  <= START;
            serOut <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
            shReg  <= {dest, len, data << ~len};
            lenR   <= len;
            remain <= HDR_BITS + {{(RW-LEN_W){1'b0}}, len};
        end else begin
            case (state)
                IDLE: begin
                    serOut <= 1'b1;
                end
                START, DEST, LEN, DATA: begin
                    if (remain == '0) begin
                        state  <= GAP;
                        serOut <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                        gapCnt <= GW'(IDLE_GAP - 1);
                        ready  <= (IDLE_GAP == 1);
                    end else begin
                        serOut <= shReg[SW-1];
                        shReg  <= {shReg[SW-2:0], 1'b0};
                        remain <= remain - 1'b1;
                        done   <= (remain == RW'(1));
                        if (remain > nBits + LEN_BITS)
                            state <= DEST;
                        else if (remain > nBits)
                            state <= LEN;
                        else
                            state <= DATA;
                    end
                end
                GAP: begin
                    // ready rises for the final gap cycle so a held start
                    // begins the next frame right after exactly IDLE_GAP idle bits.
                    if (gapCnt == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                        ready  <= (gapCnt == GW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mssd_frame_tx.sv
// tb/tb_mssd_frame_tx.sv - self-checking bench for mssd_frame_tx against a frame-level reference model
module tb_mssd_frame_tx;
    localparam int G  = 2;
    localparam int LW = 4;
    localparam int DW = 2**LW - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    dest;
    logic [LW-1:0] len;
    logic [DW-1:0] data;
    logic          serOut, ready, busy, done;

    int nCmp = 0;
    int nBad = 0;

    mssd_frame_tx #(.IDLE_GAP(G), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .dest(dest), .len(len), .data(data),
        .serOut(serOut), .ready(ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        nCmp++;
        assert (obs === expv) else begin
            nBad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Expected line contents: start bit, dest MSB first, len MSB first, data[N-1..0].
    function automatic int buildFrame(input logic [1:0] d, input logic [LW-1:0] l,
                                      input logic [DW-1:0] dat, output logic bits[64]);
        int n = 0;
        for (int i = 0; i < 64; i++) bits[i] = 1'b1;
        bits[n++] = 1'b0;
        for (int i = 1; i >= 0; i--) bits[n++] = d[i];
        for (int i = LW - 1; i >= 0; i--) bits[n++] = l[i];
        for (int i = int'(l) - 1; i >= 0; i--) bits[n++] = dat[i];
        return n;
    endfunction

    // Called at a negedge with ready expected high; returns at the negedge of the last gap cycle.
    task automatic runFrame(input string tag, input logic [1:0] d, input logic [LW-1:0] l,
                            input logic [DW-1:0] dat, input bit holdStart, input int pokeAt,
                            output int busyCycles);
        logic bits[64];
        int f;
        f = buildFrame(d, l, dat, bits);
        busyCycles = 0;
        chk({tag, ".readyBefore"}, ready, 1'b1);
        start = 1'b1; dest = d; len = l; data = dat;
        @(posedge clk);
        for (int k = 0; k < f + G; k++) begin
            @(negedge clk);
            if (!holdStart) begin
                start = (k == pokeAt);
                dest  = (k == pokeAt) ? 2'b00 : 2'($urandom);
                len   = (k == pokeAt) ? 4'd2 : LW'($urandom);
                data  = DW'($urandom);
            end
            if (busy === 1'b1) busyCycles++;
            chk($sformatf("%s.serOut[%0d]", tag, k), serOut, bits[k]);
            chk($sformatf("%s.done[%0d]", tag, k), done, k == f - 1);
            chk($sformatf("%s.busy[%0d]", tag, k), busy, k < f);
            chk($sformatf("%s.ready[%0d]", tag, k), ready, k == f + G - 1);
        end
    endtask

    initial begin
        int bc;
        logic bits[64];
        int f;
        rst = 1'b1; start = 1'b1; dest = 2'b11; len = 4'd3; data = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset.serOut", serOut, 1'b1);
        chk("reset.ready", ready, 1'b1);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle.serOut", serOut, 1'b1);

        runFrame("basic", 2'b01, 4'd3, 15'b101, 1'b0, -1, bc);
        @(negedge clk);
        runFrame("zero", 2'b10, 4'd0, 15'h7FFF, 1'b0, -1, bc);
        @(negedge clk);
        runFrame("max", 2'b11, 4'd15, 15'h5555, 1'b0, -1, bc);
        nCmp++;
        assert (bc === 22) else begin
            nBad++;
            $error("FAIL max.busyCycles observed=%0d expected=%0d", bc, 22);
        end

        @(negedge clk);
        runFrame("reject", 2'b01, 4'd4, 15'h000A, 1'b0, 3, bc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("reject.idleSer[%0d]", i), serOut, 1'b1);
            chk($sformatf("reject.idleBusy[%0d]", i), busy, 1'b0);
        end

        for (int r = 0; r < 3; r++)
            runFrame($sformatf("b2b%0d", r), 2'b10, 4'd1, 15'd1, 1'b1, -1, bc);
        start = 1'b0;
        @(negedge clk);
        chk("b2b.tailSer", serOut, 1'b1);

        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            runFrame($sformatf("rnd%0d", r), 2'($urandom), LW'($urandom), DW'($urandom),
                     1'b0, int'($urandom_range(0, 6)), bc);
        end

        // Abort a len=5 frame two bits into its data phase.
        @(negedge clk);
        f = buildFrame(2'b01, 4'd5, 15'h7FEA, bits);
        start = 1'b1; dest = 2'b01; len = 4'd5; data = 15'h7FEA;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("abort.serOut[%0d]", k), serOut, bits[k]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.serOut", serOut, 1'b1);
        chk("abort.ready", ready, 1'b1);
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        runFrame("afterAbort", 2'b11, 4'd5, 15'h0013, 1'b0, -1, bc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
